// File: rtl/serial_subtractor_pkg.sv
// Shared constants and FSM state type for the bit-serial subtractor.
package serial_subtractor_pkg;

  localparam int unsigned WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_subtractor_full_sub_cell.sv
// One-bit full subtractor built from the NOR-based gate library.
// The library primitives live here so the cell is self-contained.

module my_nor (
  output logic y,
  input  logic a,
  input  logic b
);
  assign y = ~(a | b);
endmodule

module my_or (
  output logic y,
  input  logic a,
  input  logic b
);
  logic n;
  my_nor u_n0 (.y(n), .a(a), .b(b));
  my_nor u_n1 (.y(y), .a(n), .b(n));
endmodule

module my_and (
  output logic y,
  input  logic a,
  input  logic b
);
  logic na, nb;
  my_nor u_na (.y(na), .a(a),  .b(a));
  my_nor u_nb (.y(nb), .a(b),  .b(b));
  my_nor u_o  (.y(y),  .a(na), .b(nb));
endmodule

module my_xor (
  output logic y,
  input  logic a,
  input  logic b
);
  logic n1, n2, n3, xn;
  // four NORs give XNOR, a fifth inverts it
  my_nor u_n1 (.y(n1), .a(a),  .b(b));
  my_nor u_n2 (.y(n2), .a(a),  .b(n1));
  my_nor u_n3 (.y(n3), .a(b),  .b(n1));
  my_nor u_n4 (.y(xn), .a(n2), .b(n3));
  my_nor u_n5 (.y(y),  .a(xn), .b(xn));
endmodule

module full_sub_cell (
  output logic d,
  output logic bo,
  input  logic a,
  input  logic b,
  input  logic bin
);
  logic axb, na, nxab, t_gen, t_prop;

  my_xor u_x0  (.y(axb),    .a(a),    .b(b));
  my_xor u_x1  (.y(d),      .a(axb),  .b(bin));
  my_nor u_na  (.y(na),     .a(a),    .b(a));
  my_nor u_nx  (.y(nxab),   .a(axb),  .b(axb));
  my_and u_gen (.y(t_gen),  .a(na),   .b(b));
  my_and u_prp (.y(t_prop), .a(nxab), .b(bin));
  my_or  u_bo  (.y(bo),     .a(t_gen), .b(t_prop));
endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: diff = a - b, LSB first,
// one bit per clock through a single full-subtractor cell.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             ovf
);

  localparam int unsigned CW = $clog2(WIDTH);

  state_t           state, state_nx;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_sr, b_sr;
  logic [WIDTH-2:0] res;
  logic [WIDTH-1:0] shifted;
  logic             borrow;
  logic             cell_d, cell_bo;
  logic             load, step, last;

  full_sub_cell u_cell (
    .d   (cell_d),
    .bo  (cell_bo),
    .a   (a_sr[0]),
    .b   (b_sr[0]),
    .bin (borrow)
  );

  // Result bits enter at the MSB; after WIDTH shifts the LSB lands at bit 0.
  assign shifted = {cell_d, res};

  assign busy = (state == RUN);
  assign done = (state == DONE);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state and datapath control decode
  always_comb begin
    state_nx = state;
    load     = 1'b0;
    step     = 1'b0;
    last     = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          load     = 1'b1;
          state_nx = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (cnt == CW'(WIDTH - 1)) begin
          last     = 1'b1;
          state_nx = DONE;
        end
      end
      DONE: begin
        if (start) begin
          load     = 1'b1;
          state_nx = RUN;
        end else begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Operand shift registers, borrow flop, bit counter and partial result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr   <= '0;
      b_sr   <= '0;
      res    <= '0;
      borrow <= 1'b0;
      cnt    <= '0;
    end else if (load) begin
      a_sr   <= a;
      b_sr   <= b;
      res    <= '0;
      borrow <= 1'b0;
      cnt    <= '0;
    end else if (step) begin
      a_sr   <= {1'b0, a_sr[WIDTH-1:1]};
      b_sr   <= {1'b0, b_sr[WIDTH-1:1]};
      res    <= shifted[WIDTH-1:1];
      borrow <= cell_bo;
      cnt    <= cnt + CW'(1);
    end
  end

  // Output registers, updated together on the final bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      diff       <= '0;
      borrow_out <= 1'b0;
      ovf        <= 1'b0;
    end else if (last) begin
      diff       <= shifted;
      borrow_out <= cell_bo;
      // on the MSB cycle the borrow flop still holds the borrow into the MSB
      ovf        <= borrow ^ cell_bo;
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor with directed and random operations.
module tb_serial_subtractor;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a, b;
  logic         busy, done, borrow_out, ovf;
  logic [W-1:0] diff;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
    .diff       (diff),
    .borrow_out (borrow_out),
    .ovf        (ovf)
  );

  always #20 clk = ~clk;

  always @(negedge clk) if (done) done_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: integer arithmetic on the operand values.
  function automatic logic [W-1:0] ref_diff(input logic [W-1:0] x, input logic [W-1:0] y);
    longint d;
    d = longint'(x) - longint'(y);
    if (d < 0) d += (longint'(1) << W);
    return W'(d);
  endfunction

  function automatic logic ref_borrow(input logic [W-1:0] x, input logic [W-1:0] y);
    return int'(x) < int'(y);
  endfunction

  function automatic logic ref_ovf(input logic [W-1:0] x, input logic [W-1:0] y);
    longint sx, sy, t, lim;
    lim = longint'(1) << (W - 1);
    sx  = (longint'(x) >= lim) ? longint'(x) - 2 * lim : longint'(x);
    sy  = (longint'(y) >= lim) ? longint'(y) - 2 * lim : longint'(y);
    t   = sx - sy;
    return (t < -lim) || (t > lim - 1);
  endfunction

  task automatic wait_done(output int cycles);
    cycles = 0;
    while (!done && cycles < 64) begin
      @(posedge clk); #1;
      cycles++;
    end
  endtask

  task automatic check_result(input string tag, input logic [W-1:0] x, input logic [W-1:0] y);
    check({tag, "_done"},   32'(done),       32'd1);
    check({tag, "_diff"},   32'(diff),       32'(ref_diff(x, y)));
    check({tag, "_borrow"}, 32'(borrow_out), 32'(ref_borrow(x, y)));
    check({tag, "_ovf"},    32'(ovf),        32'(ref_ovf(x, y)));
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] x, input logic [W-1:0] y);
    int n;
    @(negedge clk);
    start = 1'b1; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0; a = W'($urandom); b = W'($urandom);
    check({tag, "_busy"}, 32'(busy), 32'd1);
    wait_done(n);
    check({tag, "_lat"}, 32'(n), 32'(W));
    check_result(tag, x, y);
    @(posedge clk); #1;
    check({tag, "_done_drop"}, 32'(done), 32'd0);
  endtask

  initial begin
    int n, dc0;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
    #5;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_diff", 32'(diff), 32'd0);
    check("rst_bo",   32'(borrow_out), 32'd0);
    check("rst_ovf",  32'(ovf), 32'd0);
    @(negedge clk); rst_n = 1'b1;

    run_op("p05m03", 8'h05, 8'h03);
    run_op("p03m05", 8'h03, 8'h05);
    run_op("p80m01", 8'h80, 8'h01);
    run_op("p7Fm FF", 8'h7F, 8'hFF);

    // back-to-back: start held through DONE with new operands
    @(negedge clk); start = 1'b1; a = 8'h05; b = 8'h03;
    @(posedge clk); #1;
    wait_done(n);
    check_result("b2b_first", 8'h05, 8'h03);
    a = 8'h10; b = 8'h10;
    @(posedge clk); #1;
    start = 1'b0;
    check("b2b_busy", 32'(busy), 32'd1);
    wait_done(n);
    check("b2b_gap", 32'(n + 1), 32'(W + 1));
    check_result("b2b_second", 8'h10, 8'h10);

    // start pulsed mid-RUN must be ignored
    @(posedge clk); #1;
    dc0 = done_cnt;
    @(negedge clk); start = 1'b1; a = 8'h05; b = 8'h03;
    @(posedge clk); #1; start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); start = 1'b1; a = 8'hAA; b = 8'h11;
    @(posedge clk); #1; start = 1'b0;
    wait_done(n);
    check_result("ign", 8'h05, 8'h03);
    repeat (4) @(posedge clk);
    #1;
    check("ign_pulses", 32'(done_cnt - dc0), 32'd1);

    // asynchronous reset in the middle of an operation
    @(negedge clk); start = 1'b1; a = 8'hF0; b = 8'h01;
    @(posedge clk); #1; start = 1'b0;
    repeat (4) @(posedge clk);
    #5;
    dc0 = done_cnt;
    rst_n = 1'b0;
    #1;
    check("mrst_busy", 32'(busy), 32'd0);
    check("mrst_done", 32'(done), 32'd0);
    check("mrst_diff", 32'(diff), 32'd0);
    check("mrst_bo",   32'(borrow_out), 32'd0);
    check("mrst_ovf",  32'(ovf), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    check("mrst_nodone", 32'(done_cnt - dc0), 32'd0);
    run_op("postrst", 8'hFF, 8'h01);

    // random operations with random idle gaps
    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] x, y;
      x = W'($urandom);
      y = W'($urandom);
      if (i == 0) begin x = '0; y = '1; end
      if (i == 1) begin x = '1; y = '1; end
      run_op($sformatf("rnd%0d", i), x, y);
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
